// File: rtl/pulse_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_meter_pkg
// Description : Shared state encoding and parameter defaults for pulse_meter.
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_meter_pkg;

    localparam int DEF_CNT_W       = 8;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_HIGH  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bit_sync.sv
`default_nettype none
// ============================================================================
// Module      : bit_sync
// Description : Multi-flop synchronizer for one asynchronous bit.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    // Fewer than two flops gives no metastability protection, so clamp.
    localparam int N = (STAGES < 2) ? 2 : STAGES;

    logic [N-1:0] sync_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[N-2:0], d};
        end
    end

    assign q = sync_q[N-1];

endmodule
`default_nettype wire

// File: rtl/pulse_meter.sv
`default_nettype none
// ============================================================================
// Module      : pulse_meter
// Description : Measures the high time of an asynchronous pulse and hands the
//               result over a valid/ready interface; counts missed pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             signal,
    input  logic             enable,
    input  logic             ready,
    output logic             valid,
    output logic [CNT_W-1:0] width,
    output logic             sat,
    output logic [CNT_W-1:0] missed,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             s;
    logic             s_prev;
    logic             s_rise;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] counter;
    logic             sat_flag;

    logic             do_load;
    logic             do_inc;
    logic             do_capture;
    logic             do_xfer;
    logic             do_miss;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (signal),
        .q       (s)
    );

    assign s_rise = s & ~s_prev;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A dropped enable wins over any pulse activity while measuring.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (enable && !s) state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (!enable)  state_nxt = ST_IDLE;
                else if (s)   state_nxt = ST_HIGH;
            end
            ST_HIGH: begin
                if (!enable)  state_nxt = ST_IDLE;
                else if (!s)  state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (valid && ready) state_nxt = (enable && !s) ? ST_ARMED : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        do_load    = 1'b0;
        do_inc     = 1'b0;
        do_capture = 1'b0;
        do_xfer    = 1'b0;
        do_miss    = 1'b0;
        case (state)
            ST_ARMED: do_load = enable && s;
            ST_HIGH: begin
                do_inc     = enable && s;
                do_capture = enable && !s;
            end
            ST_HOLD: begin
                do_xfer = valid && ready;
                do_miss = s_rise;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s_prev   <= 1'b0;
            counter  <= '0;
            sat_flag <= 1'b0;
            valid    <= 1'b0;
            width    <= '0;
            sat      <= 1'b0;
            missed   <= '0;
            count    <= '0;
        end else begin
            s_prev <= s;

            // The first high sample is counted by the load itself.
            if (do_load) begin
                counter  <= CNT_W'(1);
                sat_flag <= 1'b0;
            end else if (do_inc) begin
                if (counter == CNT_MAX) begin
                    sat_flag <= 1'b1;
                end else begin
                    counter <= counter + 1'b1;
                end
            end else if (do_xfer) begin
                sat_flag <= 1'b0;
            end

            if (do_capture) begin
                valid <= 1'b1;
                width <= counter;
                sat   <= sat_flag;
            end else if (do_xfer) begin
                valid <= 1'b0;
                count <= count + 1'b1;
            end

            if (do_miss && (missed != CNT_MAX)) begin
                missed <= missed + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pulse_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pulse_meter
// Description : Randomized bench for pulse_meter against a pulse-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_meter;

    localparam int SYNC = 2;

    logic       clock;
    logic       reset_n;
    logic       signal;
    logic       enable;
    logic       ready;

    logic       valid;
    logic [7:0] width;
    logic       sat;
    logic [7:0] missed;
    logic [7:0] count;

    logic       valid4;
    logic [3:0] width4;
    logic       sat4;
    logic [3:0] missed4;
    logic [3:0] count4;

    int n_total = 0;
    int n_bad   = 0;
    int exp_count  = 0;
    int exp_missed = 0;

    pulse_meter #(.CNT_W(8), .SYNC_STAGES(SYNC)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .signal  (signal),
        .enable  (enable),
        .ready   (ready),
        .valid   (valid),
        .width   (width),
        .sat     (sat),
        .missed  (missed),
        .count   (count)
    );

    pulse_meter #(.CNT_W(4), .SYNC_STAGES(SYNC)) dut4 (
        .clock   (clock),
        .reset_n (reset_n),
        .signal  (signal),
        .enable  (enable),
        .ready   (ready),
        .valid   (valid4),
        .width   (width4),
        .sat     (sat4),
        .missed  (missed4),
        .count   (count4)
    );

    initial clock = 1'b0;
    always #12 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    function automatic int clip(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic check_counters(input string tag);
        check_eq({tag, "_count"},   count,   exp_count % 256);
        check_eq({tag, "_count4"},  count4,  exp_count % 16);
        check_eq({tag, "_missed"},  missed,  clip(exp_missed, 255));
        check_eq({tag, "_missed4"}, missed4, clip(exp_missed, 15));
    endtask

    // Pulse of n sampled-high edges; with hold, k extra pulses arrive while the
    // result is pending and are expected to be counted as missed.
    task automatic measure(input int n, input bit hold, input int k);
        int  lat;
        bit  got;
        ready  = hold ? 1'b0 : 1'b1;
        signal = 1'b1;
        repeat (n) cyc();
        signal = 1'b0;
        lat = 0;
        got = 1'b0;
        while (lat < 40 && !got) begin
            cyc();
            lat++;
            if (valid) got = 1'b1;
        end
        check_eq("latency", lat, SYNC + 1);
        check_eq("width",   width,  clip(n, 255));
        check_eq("sat",     sat,    n > 255);
        check_eq("valid4",  valid4, 1);
        check_eq("width4",  width4, clip(n, 15));
        check_eq("sat4",    sat4,   n > 15);
        if (hold) begin
            for (int i = 0; i < k; i++) begin
                signal = 1'b1;
                repeat ($urandom_range(1, 3)) cyc();
                signal = 1'b0;
                repeat (2) cyc();
                exp_missed++;
            end
            repeat (4) cyc();
            check_eq("hold_valid", valid, 1);
            check_eq("hold_width", width, clip(n, 255));
            check_counters("hold");
            ready = 1'b1;
            cyc();
            ready = 1'b0;
        end else begin
            cyc();
        end
        exp_count++;
        check_eq("post_valid", valid, 0);
        check_counters("post");
    endtask

    task automatic abort_pulse(input int n, input int drop_at);
        bit seen;
        seen   = 1'b0;
        signal = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i == drop_at) enable = 1'b0;
            cyc();
        end
        signal = 1'b0;
        repeat (10) begin
            cyc();
            if (valid) seen = 1'b1;
        end
        check_eq("abort_no_valid", seen, 0);
        check_counters("abort");
        enable = 1'b1;
        repeat (3) cyc();
    endtask

    initial begin
        int  n;
        int  mode;
        bit  seen;
        reset_n = 1'b0;
        signal  = 1'b0;
        enable  = 1'b0;
        ready   = 1'b0;
        repeat (3) cyc();
        check_eq("rst_valid",  valid,  0);
        check_eq("rst_width",  width,  0);
        check_eq("rst_sat",    sat,    0);
        check_counters("rst");
        reset_n = 1'b1;
        enable  = 1'b1;
        repeat (3) cyc();

        measure(5, 1'b0, 0);
        measure(20, 1'b0, 0);
        measure(3, 1'b1, 2);
        abort_pulse(6, 2);

        // Pulse already high when enable rises must be ignored.
        enable = 1'b0;
        signal = 1'b1;
        repeat (4) cyc();
        enable = 1'b1;
        repeat (4) cyc();
        signal = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            cyc();
            if (valid) seen = 1'b1;
        end
        check_eq("prehigh_no_valid", seen, 0);
        measure(4, 1'b0, 0);

        for (int it = 0; it < 40; it++) begin
            n = $urandom_range(1, 24);
            if (n == 15) n = 16;
            mode = $urandom_range(0, 2);
            if (mode == 2 && n >= 6) begin
                abort_pulse(n, $urandom_range(3, n - 1));
            end else begin
                measure(n, mode == 1, $urandom_range(0, 3));
            end
            repeat ($urandom_range(1, 4)) cyc();
        end

        // Reset while a result is pending.
        ready  = 1'b0;
        signal = 1'b1;
        repeat (6) cyc();
        signal = 1'b0;
        repeat (SYNC + 3) cyc();
        check_eq("prerst_valid", valid, 1);
        reset_n = 1'b0;
        #1;
        exp_count  = 0;
        exp_missed = 0;
        check_eq("hrst_valid", valid, 0);
        check_eq("hrst_width", width, 0);
        check_eq("hrst_sat",   sat,   0);
        check_eq("hrst_valid4", valid4, 0);
        check_counters("hrst");
        cyc();
        reset_n = 1'b1;
        repeat (3) cyc();
        measure(7, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
